// File: rtl/instruction_fetch_unit_if.sv
// Instruction-side bus bundle: instruction memory req/ack port plus the
// instruction hand-off to the control unit / datapath.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        PCSel;
  logic [31:0] alu_target;
  logic [1:0]  fetch_err;
  logic [31:0] instret;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_err, instret,
    input  imem_ack, imem_rdata, inst_ready, PCSel, alu_target
  );

  // Memory / consumer side
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_err, instret,
    output imem_ack, imem_rdata, inst_ready, PCSel, alu_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack handshake,
// presents inst/inst_pc until accepted, then selects the next PC.
// Fetch timeouts and misaligned targets latch a sticky error and park the FSM.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                      Clock,
  input logic                      Reset_n,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] instret_q, instret_d;

  logic        accept;
  logic [31:0] target;
  logic [31:0] nxt_pc;

  assign accept = (state_q == StHold) && bus.inst_ready;
  // Bit 0 of a jump target is always discarded; bit 1 set means misaligned.
  assign target = bus.alu_target & ~32'h1;
  assign nxt_pc = bus.PCSel ? target : inst_pc_q + 32'd4;

  // State and datapath registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic: fetch, hold until accept, pick next PC, trap on errors
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    instret_d = instret_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        // An ack arriving on the final allowed cycle still wins over the timeout
        if (bus.imem_ack) begin
          inst_d    = bus.imem_rdata;
          inst_pc_d = pc_q;
          cnt_d     = '0;
          state_d   = StHold;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          err_d   = 2'b01;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (accept) begin
          instret_d = instret_q + 32'd1;
          if (nxt_pc[1]) begin
            err_d   = 2'b10;
            state_d = StErr;
          end else begin
            pc_d    = nxt_pc;
            state_d = StReq;
          end
        end
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  assign bus.imem_req   = (state_q == StReq);
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = (state_q == StHold);
  assign bus.fetch_err  = err_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small wait-state memory model.
module tb_instruction_fetch_unit;

  localparam int unsigned Timeout = 16;

  logic Clock;
  logic Reset_n;
  int   checks;
  int   failures;

  logic       mem_on;
  logic [7:0] wait_states;
  logic [7:0] req_age;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return 32'hA500_0013 ^ addr;
  endfunction

  // Memory model: ack after wait_states cycles of continuous request
  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) req_age <= '0;
    else if (bus.imem_req && !bus.imem_ack) req_age <= req_age + 8'd1;
    else req_age <= '0;
  end
  assign bus.imem_ack   = bus.imem_req && mem_on && (req_age == wait_states);
  assign bus.imem_rdata = inst_of(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for inst_valid at a falling edge; report number of edges waited
  task automatic wait_valid(input int max, output int steps);
    steps = 0;
    while (bus.inst_valid !== 1'b1 && steps < max) begin
      @(negedge Clock);
      steps++;
    end
    check("wait_valid", {31'd0, bus.inst_valid}, 32'd1);
  endtask

  // Present ready for exactly one cycle with the given next-PC selection
  task automatic accept_one(input logic sel, input logic [31:0] tgt);
    bus.inst_ready = 1'b1;
    bus.PCSel      = sel;
    bus.alu_target = tgt;
    @(negedge Clock);
    bus.inst_ready = 1'b0;
    bus.PCSel      = 1'b0;
    bus.alu_target = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    logic [31:0] exp_pc;
    checks         = 0;
    failures       = 0;
    Reset_n        = 1'b0;
    mem_on         = 1'b1;
    wait_states    = 8'd0;
    bus.inst_ready = 1'b0;
    bus.PCSel      = 1'b0;
    bus.alu_target = 32'h0;

    // Reset state
    repeat (2) @(negedge Clock);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_err", {30'd0, bus.fetch_err}, 32'd0);
    check("rst_instret", bus.instret, 32'd0);

    // First request one cycle after reset release
    Reset_n = 1'b1;
    @(negedge Clock);
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);

    // Sequential fetch with zero-wait memory
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      wait_valid(4, steps);
      check("seq_inst_pc", bus.inst_pc, exp_pc);
      check("seq_inst", bus.inst, inst_of(exp_pc));
      accept_one(1'b0, 32'h0);
      check("seq_instret", bus.instret, 32'(i + 1));
      check("seq_valid_drop", {31'd0, bus.inst_valid}, 32'd0);
      check("seq_next_addr", bus.imem_addr, exp_pc + 32'd4);
      // Zero-wait latency: valid again exactly one more edge later
      wait_valid(4, steps);
      check("seq_latency", 32'(steps), 32'd1);
    end

    // Jump target with bit 0 set is cleared
    check("jmp_src_pc", bus.inst_pc, 32'h10);
    accept_one(1'b1, 32'h41);
    check("jmp_addr", bus.imem_addr, 32'h40);
    check("jmp_req", {31'd0, bus.imem_req}, 32'd1);
    wait_valid(4, steps);
    check("jmp_inst_pc", bus.inst_pc, 32'h40);
    check("jmp_inst", bus.inst, inst_of(32'h40));

    // Three wait states, then consumer stalls for five cycles
    wait_states = 8'd3;
    accept_one(1'b0, 32'h0);
    check("ws_ack_low", {31'd0, bus.imem_ack}, 32'd0);
    wait_valid(10, steps);
    check("ws_latency", 32'(steps), 32'd4);
    for (int k = 0; k < 5; k++) begin
      bus.PCSel      = 1'b1;
      bus.alu_target = 32'h0000_0102;
      @(negedge Clock);
      check("stall_inst_pc", bus.inst_pc, 32'h44);
      check("stall_inst", bus.inst, inst_of(32'h44));
      check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("stall_instret", bus.instret, 32'd6);
      check("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.PCSel      = 1'b0;
    bus.alu_target = 32'h0;

    // Ack on the last allowed cycle beats the timeout
    wait_states = 8'(Timeout - 1);
    accept_one(1'b0, 32'h0);
    wait_valid(40, steps);
    check("late_ack_steps", 32'(steps), 32'(Timeout));
    check("late_ack_pc", bus.inst_pc, 32'h48);
    check("late_ack_err", {30'd0, bus.fetch_err}, 32'd0);

    // No ack at all: timeout error after MEM_TIMEOUT request cycles
    wait_states = 8'd0;
    mem_on      = 1'b0;
    accept_one(1'b0, 32'h0);
    repeat (Timeout - 1) @(negedge Clock);
    check("to_last_req", {31'd0, bus.imem_req}, 32'd1);
    check("to_last_err", {30'd0, bus.fetch_err}, 32'd0);
    @(negedge Clock);
    check("to_err", {30'd0, bus.fetch_err}, 32'd1);
    check("to_req", {31'd0, bus.imem_req}, 32'd0);
    check("to_valid", {31'd0, bus.inst_valid}, 32'd0);
    mem_on = 1'b1;
    repeat (3) @(negedge Clock);
    check("to_absorb_req", {31'd0, bus.imem_req}, 32'd0);
    check("to_sticky", {30'd0, bus.fetch_err}, 32'd1);

    // Reset from ERR, then reset again in the middle of a waiting request
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n     = 1'b1;
    wait_states = 8'd5;
    @(negedge Clock);
    check("mid_req", {31'd0, bus.imem_req}, 32'd1);
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_err", {30'd0, bus.fetch_err}, 32'd0);
    @(negedge Clock);
    Reset_n     = 1'b1;
    wait_states = 8'd0;
    @(negedge Clock);
    check("rel_addr", bus.imem_addr, 32'h0);
    wait_valid(4, steps);
    check("rel_inst_pc", bus.inst_pc, 32'h0);
    check("rel_instret", bus.instret, 32'd0);

    // PC wraps modulo 2^32 without error
    accept_one(1'b1, 32'hFFFF_FFFC);
    check("wrap_src_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_valid(4, steps);
    check("wrap_src_pc", bus.inst_pc, 32'hFFFF_FFFC);
    accept_one(1'b0, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_err", {30'd0, bus.fetch_err}, 32'd0);
    wait_valid(4, steps);
    check("wrap_inst_pc", bus.inst_pc, 32'h0);

    // Misaligned target traps without issuing a fetch
    accept_one(1'b1, 32'h10);
    wait_valid(4, steps);
    check("mis_src_pc", bus.inst_pc, 32'h10);
    accept_one(1'b1, 32'h42);
    check("mis_err", {30'd0, bus.fetch_err}, 32'd2);
    check("mis_req", {31'd0, bus.imem_req}, 32'd0);
    check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("mis_instret", bus.instret, 32'd4);
    bus.inst_ready = 1'b1;
    repeat (3) @(negedge Clock);
    check("mis_absorb_req", {31'd0, bus.imem_req}, 32'd0);
    check("mis_absorb_instret", bus.instret, 32'd4);
    check("mis_sticky", {30'd0, bus.fetch_err}, 32'd2);
    bus.inst_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
